// File: rtl/alu_div_nr.sv
// alu_div_nr: sequential non-restoring divider, signed or unsigned.
// A W-bit divide takes W iteration cycles, one correction cycle and one
// result-load cycle. Divide-by-zero and signed overflow skip straight to the
// result-load cycle. Results are registered and held until the next valid.
module alu_div_nr #(
    parameter int unsigned DATA_WL = 16
) (
    input  logic               clk,
    input  logic               a_reset_l,
    input  logic               start,
    input  logic               signed_op,
    input  logic [DATA_WL-1:0] a_in,
    input  logic [DATA_WL-1:0] b_in,
    output logic               busy,
    output logic               valid,
    output logic [DATA_WL-1:0] q_out,
    output logic [DATA_WL-1:0] r_out,
    output logic               z_flag,
    output logic               dz_flag,
    output logic               ovr_flag
);

    localparam int unsigned CNT_WL = (DATA_WL > 1) ? $clog2(DATA_WL) : 1;
    localparam logic [DATA_WL-1:0] MIN_NEG = {1'b1, {(DATA_WL - 1){1'b0}}};
    localparam logic [DATA_WL-1:0] ALL_ONES = {DATA_WL{1'b1}};
    localparam logic [CNT_WL-1:0] CNT_LOAD = CNT_WL'(DATA_WL - 1);
    localparam logic [CNT_WL-1:0] CNT_ONE = CNT_WL'(1);

    typedef enum logic [1:0] {StIdle, StIter, StCorr, StDone} state_e;

    state_e             state_q;
    logic [CNT_WL-1:0]  cnt_q;
    // Partial remainder, signed, one bit wider than the operands.
    logic [DATA_WL:0]   p_q;
    // Dividend magnitude on entry; shifts out dividend bits and shifts in
    // quotient bits. Holds the signed quotient after correction.
    logic [DATA_WL-1:0] quo_q;
    logic [DATA_WL-1:0] div_q;
    logic [DATA_WL-1:0] a_raw_q;
    logic               sign_q_q;
    logic               sign_r_q;
    logic               dz_q;
    logic               ovr_q;

    logic               a_neg;
    logic               b_neg;
    logic [DATA_WL-1:0] a_mag;
    logic [DATA_WL-1:0] b_mag;
    logic               is_dz;
    logic               is_ovr;
    logic [DATA_WL:0]   d_ext;
    logic [DATA_WL:0]   p_shift;
    logic [DATA_WL:0]   p_step;
    logic [DATA_WL-1:0] quo_step;
    logic [DATA_WL:0]   p_fix;
    logic [DATA_WL-1:0] rem_mag;
    logic [DATA_WL-1:0] q_signed;
    logic [DATA_WL-1:0] r_signed;
    logic [DATA_WL-1:0] q_final;
    logic [DATA_WL-1:0] r_final;

    // Operand preparation and special-case detection on the raw inputs.
    always_comb begin
        a_neg  = signed_op & a_in[DATA_WL-1];
        b_neg  = signed_op & b_in[DATA_WL-1];
        // |MIN_NEG| still fits as an unsigned W-bit magnitude.
        a_mag  = a_neg ? -a_in : a_in;
        b_mag  = b_neg ? -b_in : b_in;
        is_dz  = (b_in == '0);
        is_ovr = signed_op && (a_in == MIN_NEG) && (b_in == ALL_ONES);
    end

    // One non-restoring step; P wraps mod 2^(W+1) but its result always fits.
    always_comb begin
        d_ext    = {1'b0, div_q};
        p_shift  = {p_q[DATA_WL-1:0], quo_q[DATA_WL-1]};
        p_step   = p_q[DATA_WL] ? (p_shift + d_ext) : (p_shift - d_ext);
        quo_step = {quo_q[DATA_WL-2:0], ~p_step[DATA_WL]};
    end

    // Remainder fix-up and sign application (truncating division).
    always_comb begin
        p_fix    = p_q[DATA_WL] ? (p_q + d_ext) : p_q;
        rem_mag  = p_fix[DATA_WL-1:0];
        q_signed = sign_q_q ? -quo_q : quo_q;
        r_signed = sign_r_q ? -rem_mag : rem_mag;
    end

    // Final result selection including divide-by-zero and overflow.
    always_comb begin
        if (dz_q) begin
            q_final = ALL_ONES;
            r_final = a_raw_q;
        end else if (ovr_q) begin
            q_final = MIN_NEG;
            r_final = '0;
        end else begin
            q_final = quo_q;
            r_final = p_q[DATA_WL-1:0];
        end
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge a_reset_l) begin
        if (!a_reset_l) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            p_q      <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            a_raw_q  <= '0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            dz_q     <= 1'b0;
            ovr_q    <= 1'b0;
            busy     <= 1'b0;
            valid    <= 1'b0;
            q_out    <= '0;
            r_out    <= '0;
            z_flag   <= 1'b0;
            dz_flag  <= 1'b0;
            ovr_flag <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (valid) begin
                        // Valid cycle is the last busy cycle; start is ignored here.
                        valid <= 1'b0;
                        busy  <= 1'b0;
                    end else if (start) begin
                        busy     <= 1'b1;
                        sign_q_q <= a_neg ^ b_neg;
                        sign_r_q <= a_neg;
                        quo_q    <= a_mag;
                        div_q    <= b_mag;
                        p_q      <= '0;
                        a_raw_q  <= a_in;
                        dz_q     <= is_dz;
                        ovr_q    <= is_ovr;
                        cnt_q    <= CNT_LOAD;
                        state_q  <= (is_dz || is_ovr) ? StDone : StIter;
                    end
                end
                StIter: begin
                    p_q   <= p_step;
                    quo_q <= quo_step;
                    if (cnt_q == '0) begin
                        state_q <= StCorr;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                StCorr: begin
                    quo_q   <= q_signed;
                    p_q     <= {1'b0, r_signed};
                    state_q <= StDone;
                end
                StDone: begin
                    q_out    <= q_final;
                    r_out    <= r_final;
                    z_flag   <= (q_final == '0);
                    dz_flag  <= dz_q;
                    ovr_flag <= ovr_q;
                    valid    <= 1'b1;
                    state_q  <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
